fsm_sync_tx: RTL and testbench



---
 rtl/fsm_sync_tx.sv | 189 ++++++++++++++++++
 tb/tb_fsm_sync_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_sync_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_sync_tx
//  Description : Serial frame transmitter. Accepts a parallel word through a
//                ready/load handshake and sends it one bit per clock on x_out:
//                SYNC_LEN ones (sync marker), one 0 guard bit, then the data
//                word MSB-first. A 0 is stuffed after every run of SYNC_LEN-1
//                data ones, so the sync pattern can only appear in the marker.
//  Optional    : `define PARITY_TX_EN appends one even-parity bit of the
//                latched word after the data field. That bit is also subject
//                to stuffing.
//  Ports       : clk       - clock, rising edge
//                reset     - asynchronous, active-low reset
//                data_in   - word to transmit, latched on an accepted load
//                load      - frame request, accepted when ready=1
//                ready     - a load is accepted at the next rising edge
//                x_out     - serial bit stream (registered)
//                tx_active - high from the first sync bit to the last data,
//                            parity or stuff bit
//                done      - one-cycle pulse in the END cycle after a frame
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_sync_tx #(
    parameter int WIDTH    = 8,
    parameter int SYNC_LEN = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             x_out,
    output logic             tx_active,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam int RW  = $clog2(SYNC_LEN + 1);

    localparam logic [BCW-1:0] LAST_BIT  = BCW'(WIDTH);
    localparam logic [BCW-1:0] BC_ONE    = BCW'(1);
    localparam logic [RW-1:0]  STUFF_AT  = RW'(SYNC_LEN - 1);
    localparam logic [RW-1:0]  SYNC_LAST = RW'(SYNC_LEN);
    localparam logic [RW-1:0]  RUN_ONE   = RW'(1);

`ifdef PARITY_TX_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_GUARD  = 3'd2,
        ST_DATA   = 3'd3,
        ST_STUFF  = 3'd4,
        ST_END    = 3'd5,
        ST_PARITY = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_GUARD  = 3'd2,
        ST_DATA   = 3'd3,
        ST_STUFF  = 3'd4,
        ST_END    = 3'd5
    } state_t;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;     // latched word, MSB is the next data bit
    logic [BCW-1:0]   r_bit_cnt;   // data bits already emitted
    logic [RW-1:0]    r_ones_run;  // consecutive ones since guard/last stuff
    logic [RW-1:0]    r_sync_cnt;  // sync ones already emitted
`ifdef PARITY_TX_EN
    logic             r_parity;
    logic             r_parity_sent;
`endif

    logic             w_msb;
    logic [RW-1:0]    w_run_msb;
    logic             w_bits_left;
    logic             w_stuff_due;

    assign w_msb       = r_shift[WIDTH-1];
    assign w_run_msb   = w_msb ? (r_ones_run + RUN_ONE) : '0;
    assign w_bits_left = (r_bit_cnt != LAST_BIT);
    // ones_run only reaches the threshold right after a data/parity one, so
    // this is never true in GUARD or STUFF where the run was just cleared.
    assign w_stuff_due = (r_ones_run == STUFF_AT);

    // Outputs are registered together with the state they belong to: every
    // transition loads x_out/tx_active/ready/done for the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_ones_run    <= '0;
            r_sync_cnt    <= '0;
`ifdef PARITY_TX_EN
            r_parity      <= 1'b0;
            r_parity_sent <= 1'b0;
`endif
            x_out         <= 1'b0;
            ready         <= 1'b1;
            tx_active     <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                // END behaves like IDLE for the handshake, which gives
                // back-to-back frames without an idle gap.
                ST_IDLE, ST_END: begin
                    if (load && ready) begin
                        r_state       <= ST_SYNC;
                        r_shift       <= data_in;
                        r_bit_cnt     <= '0;
                        r_ones_run    <= '0;
                        r_sync_cnt    <= RUN_ONE;
`ifdef PARITY_TX_EN
                        r_parity      <= ^data_in;
                        r_parity_sent <= 1'b0;
`endif
                        x_out         <= 1'b1;
                        tx_active     <= 1'b1;
                        ready         <= 1'b0;
                    end else begin
                        r_state   <= ST_IDLE;
                        x_out     <= 1'b0;
                        tx_active <= 1'b0;
                        ready     <= 1'b1;
                    end
                end

                ST_SYNC: begin
                    if (r_sync_cnt == SYNC_LAST) begin
                        r_state    <= ST_GUARD;
                        r_ones_run <= '0;
                        x_out      <= 1'b0;
                    end else begin
                        r_sync_cnt <= r_sync_cnt + RUN_ONE;
                        x_out      <= 1'b1;
                    end
                end

                // GUARD, DATA, STUFF (and PARITY) share one decision: stuff
                // if the run limit was hit, else send the next data bit, else
                // close the frame (via the parity bit when enabled).
`ifdef PARITY_TX_EN
                ST_GUARD, ST_DATA, ST_STUFF, ST_PARITY: begin
`else
                ST_GUARD, ST_DATA, ST_STUFF: begin
`endif
                    if (w_stuff_due) begin
                        r_state    <= ST_STUFF;
                        r_ones_run <= '0;
                        x_out      <= 1'b0;
                    end else if (w_bits_left) begin
                        r_state    <= ST_DATA;
                        r_shift    <= {r_shift[WIDTH-2:0], 1'b0};
                        r_bit_cnt  <= r_bit_cnt + BC_ONE;
                        r_ones_run <= w_run_msb;
                        x_out      <= w_msb;
`ifdef PARITY_TX_EN
                    end else if (!r_parity_sent) begin
                        r_state       <= ST_PARITY;
                        r_parity_sent <= 1'b1;
                        r_ones_run    <= r_parity ? (r_ones_run + RUN_ONE) : '0;
                        x_out         <= r_parity;
`endif
                    end else begin
                        r_state   <= ST_END;
                        x_out     <= 1'b0;
                        tx_active <= 1'b0;
                        ready     <= 1'b1;
                        done      <= 1'b1;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    x_out     <= 1'b0;
                    tx_active <= 1'b0;
                    ready     <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fsm_sync_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsm_sync_tx
//  Description : Self-checking bench for fsm_sync_tx. A bit-level frame model
//                pushes the expected per-cycle outputs into a queue when a
//                load is accepted; a monitor pops and compares on every
//                falling edge. Also covers reset state, frame lengths, ignored
//                loads, back-to-back frames and reset mid-frame. Honours
//                PARITY_TX_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_sync_tx;

    localparam int W  = 8;
    localparam int SL = 3;
`ifdef PARITY_TX_EN
    localparam int PX = 1;
`else
    localparam int PX = 0;
`endif

    logic         clk     = 1'b0;
    logic         reset   = 1'b0;
    logic         load    = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         ready;
    logic         x_out;
    logic         tx_active;
    logic         done;

    fsm_sync_tx #(
        .WIDTH    (W),
        .SYNC_LEN (SL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .load      (load),
        .ready     (ready),
        .x_out     (x_out),
        .tx_active (tx_active),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic x;
        logic act;
        logic dn;
        logic rdy;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_checks   = 0;
    int   n_errors   = 0;
    bit   mon_en     = 1'b0;
    int   act_cycles = 0;
    int   act_base   = 0;
    int   cur_len    = 0;
    int   run        = 0;
    bit   in_data    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic x, input logic a, input logic d, input logic r);
        exp_t e;
        e.x   = x;
        e.act = a;
        e.dn  = d;
        e.rdy = r;
        return e;
    endfunction

    // One data (or parity) bit followed by a stuffed 0 when the run of ones
    // reaches SL-1.
    task automatic push_bit(input logic b, inout int r);
        q.push_back(mk(b, 1'b1, 1'b0, 1'b0));
        r = b ? r + 1 : 0;
        if (r == SL - 1) begin
            q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
            r = 0;
        end
    endtask

    task automatic push_frame(input logic [W-1:0] d);
        int r = 0;
        for (int i = 0; i < SL; i++) q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = W - 1; i >= 0; i--) push_bit(d[i], r);
`ifdef PARITY_TX_EN
        push_bit(^d, r);
`endif
        q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1));
    endtask

    always @(negedge clk) begin
        if (tx_active === 1'b1) act_cycles++;
        if (mon_en && q.size() > 0) begin
            cur = q.pop_front();
            check("x_out",     {31'b0, x_out},     {31'b0, cur.x});
            check("tx_active", {31'b0, tx_active}, {31'b0, cur.act});
            check("done",      {31'b0, done},      {31'b0, cur.dn});
            check("ready",     {31'b0, ready},     {31'b0, cur.rdy});
        end
        if (mon_en) begin
            if (tx_active !== 1'b1) begin
                in_data = 1'b0;
                run     = 0;
            end else if (x_out === 1'b0) begin
                in_data = 1'b1;
                run     = 0;
            end else if (in_data) begin
                run++;
                check("no_sync_in_data", {31'b0, (run >= SL)}, 32'd0);
            end
        end
    end

    // Drives load with inputs already stable; pushes the model after the edge.
    task automatic accept(input logic [W-1:0] d, input int exp_len);
        data_in = d;
        load    = 1'b1;
        @(posedge clk);
        #1;
        push_frame(d);
        act_base = act_cycles;
        cur_len  = exp_len;
        load     = 1'b0;
        data_in  = ~d;
    endtask

    task automatic send(input logic [W-1:0] d, input int exp_len);
        int i = 0;
        @(negedge clk);
        while (ready !== 1'b1 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("ready_before_load", {31'b0, ready}, 32'd1);
        accept(d, exp_len);
    endtask

    task automatic drain();
        int i = 0;
        while (q.size() != 0 && i < 200) begin
            @(posedge clk);
            i++;
        end
        check("drain_done", q.size(), 32'd0);
        check("frame_len", act_cycles - act_base, cur_len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected test end");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_x_out",     {31'b0, x_out},     32'd0);
        check("rst_ready",     {31'b0, ready},     32'd1);
        check("rst_tx_active", {31'b0, tx_active}, 32'd0);
        check("rst_done",      {31'b0, done},      32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;

        send(8'hA5, 12 + PX); drain();
        send(8'hFF, 16 + PX); drain();
        send(8'h00, 12 + PX); drain();
        send(8'h07, (PX != 0) ? 15 : 13); drain();

        // load during DATA must be ignored, then back-to-back from END
        send(8'h5A, 13 + PX);
        repeat (6) @(negedge clk);
        check("ready_in_data", {31'b0, ready},     32'd0);
        check("active_in_data", {31'b0, tx_active}, 32'd1);
        load    = 1'b1;
        data_in = 8'hFF;
        @(negedge clk);
        load = 1'b0;
        begin
            int i = 0;
            while (done !== 1'b1 && i < 100) begin
                @(negedge clk);
                i++;
            end
        end
        check("end_done",  {31'b0, done},  32'd1);
        check("end_ready", {31'b0, ready}, 32'd1);
        check("frame_len_5A", act_cycles - act_base, 13 + PX);
        accept(8'h3C, 14 + PX);
        drain();
        @(negedge clk);
        check("idle_x_out",  {31'b0, x_out},     32'd0);
        check("idle_active", {31'b0, tx_active}, 32'd0);
        check("idle_ready",  {31'b0, ready},     32'd1);
        check("idle_done",   {31'b0, done},      32'd0);

        // reset during the 3rd data bit of 0xFF
        send(8'hFF, 16 + PX);
        repeat (8) @(negedge clk);
        #2;
        reset  = 1'b0;
        mon_en = 1'b0;
        q.delete();
        #1;
        check("abort_x_out",  {31'b0, x_out},     32'd0);
        check("abort_ready",  {31'b0, ready},     32'd1);
        check("abort_active", {31'b0, tx_active}, 32'd0);
        check("abort_done",   {31'b0, done},      32'd0);
        repeat (3) begin
            @(negedge clk);
            check("no_done_in_reset", {31'b0, done}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_done",  {31'b0, done},  32'd0);
        check("post_rst_ready", {31'b0, ready}, 32'd1);
        check("post_rst_x_out", {31'b0, x_out}, 32'd0);
        in_data = 1'b0;
        run     = 0;
        mon_en  = 1'b1;
        send(8'hC3, 14 + PX); drain();
        send(8'hA5, 12 + PX); drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
